// File: rtl/bnn_frame_ctrl.sv
// rtl/bnn_frame_ctrl.sv - frame sequencer for the binary CNN core: pixel gating, result watchdog, flush.
// Optional accepted-result counter enabled by defining BNN_FRAME_CNT_EN.
module bnn_frame_ctrl #(
   parameter int IMG_W       = 28,
   parameter int IMG_H       = 28,
   parameter int NUM_CLASSES = 10,
   parameter int CONF_W      = 8,
   parameter int TIMEOUT_CYC = 4096,
   localparam int CLS_W      = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic              s_data,
   input  logic              s_last,
   output logic              core_en,
   output logic              core_pixel,
   output logic              core_flush,
   input  logic              core_valid,
   input  logic [CLS_W-1:0]  core_class,
   input  logic [CONF_W-1:0] core_conf,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [CLS_W-1:0]  res_class,
   output logic [CONF_W-1:0] res_conf,
   output logic [1:0]        res_err,
   output logic              busy,
   output logic [15:0]       frame_cnt
);

   localparam int N     = IMG_W * IMG_H;
   localparam int PIX_W = $clog2(N + 1);
   localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);
   localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(N - 1);
   localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {ST_LOAD, ST_WAIT, ST_RESULT, ST_FLUSH} state_t;

   state_t              state, state_nx;
   logic [PIX_W-1:0]    pix_cnt, pix_nx;
   logic [WD_W-1:0]     wd_cnt, wd_nx;
   logic [1:0]          err_nx;
   logic [CLS_W-1:0]    cls_nx;
   logic [CONF_W-1:0]   conf_nx;
   logic                s_ready_nx, res_valid_nx, busy_nx;
   logic                core_en_nx, core_pixel_nx, core_flush_nx;
   logic                accept;

   assign accept = (state == ST_LOAD) && s_valid && s_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= ST_LOAD;
         pix_cnt    <= '0;
         wd_cnt     <= '0;
         s_ready    <= 1'b1;
         core_en    <= 1'b0;
         core_pixel <= 1'b0;
         core_flush <= 1'b0;
         res_valid  <= 1'b0;
         res_class  <= '0;
         res_conf   <= '0;
         res_err    <= 2'b00;
         busy       <= 1'b0;
      end else begin
         state      <= state_nx;
         pix_cnt    <= pix_nx;
         wd_cnt     <= wd_nx;
         s_ready    <= s_ready_nx;
         core_en    <= core_en_nx;
         core_pixel <= core_pixel_nx;
         core_flush <= core_flush_nx;
         res_valid  <= res_valid_nx;
         res_class  <= cls_nx;
         res_conf   <= conf_nx;
         res_err    <= err_nx;
         busy       <= busy_nx;
      end
   end

   always_comb begin
      state_nx      = state;
      pix_nx        = pix_cnt;
      wd_nx         = wd_cnt;
      err_nx        = res_err;
      cls_nx        = res_class;
      conf_nx       = res_conf;
      s_ready_nx    = s_ready;
      res_valid_nx  = res_valid;
      core_en_nx    = 1'b0;
      core_pixel_nx = 1'b0;
      core_flush_nx = 1'b0;
      case (state)
         ST_LOAD: begin
            if (accept) begin
               core_en_nx    = 1'b1;
               core_pixel_nx = s_data;
               if (pix_cnt == PIX_LAST) begin
                  // A missing s_last is flagged but the core still sees a full image.
                  state_nx   = ST_WAIT;
                  pix_nx     = '0;
                  wd_nx      = '0;
                  s_ready_nx = 1'b0;
                  if (!s_last) err_nx[0] = 1'b1;
               end else if (s_last) begin
                  state_nx     = ST_RESULT;
                  pix_nx       = '0;
                  s_ready_nx   = 1'b0;
                  err_nx[0]    = 1'b1;
                  cls_nx       = '0;
                  conf_nx      = '0;
                  res_valid_nx = 1'b1;
               end else begin
                  pix_nx = pix_cnt + PIX_W'(1);
               end
            end
         end
         ST_WAIT: begin
            wd_nx = wd_cnt + WD_W'(1);
            if (core_valid) begin
               state_nx     = ST_RESULT;
               cls_nx       = core_class;
               conf_nx      = core_conf;
               res_valid_nx = 1'b1;
            end else if (wd_cnt == WD_LAST) begin
               state_nx     = ST_RESULT;
               err_nx[1]    = 1'b1;
               cls_nx       = '0;
               conf_nx      = '0;
               res_valid_nx = 1'b1;
            end
         end
         ST_RESULT: begin
            if (res_ready) begin
               state_nx      = ST_FLUSH;
               res_valid_nx  = 1'b0;
               core_flush_nx = 1'b1;
            end
         end
         ST_FLUSH: begin
            state_nx   = ST_LOAD;
            err_nx     = 2'b00;
            s_ready_nx = 1'b1;
         end
         default: state_nx = ST_LOAD;
      endcase
      busy_nx = !((state_nx == ST_LOAD) && (pix_nx == '0));
   end

`ifdef BNN_FRAME_CNT_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         frame_cnt <= 16'h0000;
      end else if (res_valid && res_ready && (frame_cnt != 16'hFFFF)) begin
         frame_cnt <= frame_cnt + 16'd1;
      end
   end
`else
   assign frame_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_bnn_frame_ctrl.sv
// tb/tb_bnn_frame_ctrl.sv - randomized directed bench for bnn_frame_ctrl against a frame-level model.
module tb_bnn_frame_ctrl;

   localparam int IMG_W  = 28;
   localparam int IMG_H  = 28;
   localparam int NCLS   = 10;
   localparam int CONF_W = 8;
   localparam int TO     = 24;
   localparam int N      = IMG_W * IMG_H;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        s_valid = 1'b0, s_data = 1'b0, s_last = 1'b0;
   logic        s_ready;
   logic        core_en, core_pixel, core_flush;
   logic        core_valid = 1'b0;
   logic [3:0]  core_class = '0;
   logic [7:0]  core_conf = '0;
   logic        res_valid;
   logic        res_ready = 1'b0;
   logic [3:0]  res_class;
   logic [7:0]  res_conf;
   logic [1:0]  res_err;
   logic        busy;
   logic [15:0] frame_cnt;

   bnn_frame_ctrl #(
      .IMG_W(IMG_W), .IMG_H(IMG_H), .NUM_CLASSES(NCLS), .CONF_W(CONF_W), .TIMEOUT_CYC(TO)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
      .core_en(core_en), .core_pixel(core_pixel), .core_flush(core_flush),
      .core_valid(core_valid), .core_class(core_class), .core_conf(core_conf),
      .res_valid(res_valid), .res_ready(res_ready), .res_class(res_class),
      .res_conf(res_conf), .res_err(res_err), .busy(busy), .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   int passed = 0;
   int total  = 0;
   int en_cnt = 0;
   int flush_cnt = 0;
   bit got_pix[$];
   bit exp_pix[$];
   int exp_fc = 0;

   always @(negedge clk) begin
      if (core_en === 1'b1) begin
         en_cnt++;
         got_pix.push_back(core_pixel);
      end
      if (core_flush === 1'b1) flush_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_vals(input string pfx);
      chk({pfx, "_s_ready"}, s_ready, 1);
      chk({pfx, "_core_en"}, core_en, 0);
      chk({pfx, "_core_pixel"}, core_pixel, 0);
      chk({pfx, "_core_flush"}, core_flush, 0);
      chk({pfx, "_res_valid"}, res_valid, 0);
      chk({pfx, "_res_class"}, res_class, 0);
      chk({pfx, "_res_conf"}, res_conf, 0);
      chk({pfx, "_res_err"}, res_err, 0);
      chk({pfx, "_busy"}, busy, 0);
      chk({pfx, "_frame_cnt"}, frame_cnt, 0);
   endtask

   // last_beat: 1-based beat carrying s_last (0 = never); core_lat: cycles after the
   // final beat at which the core answers (outside 1..TO means it stays silent).
   task automatic run_frame(input int nbeats, input int last_beat, input int core_lat,
                            input int hold, input logic [3:0] cls, input logic [7:0] conf);
      int en0, q0, fl0, bad_ready, early_res, bad_hold, resp, mism;
      bit timed_out;
      logic [1:0] e_err;
      logic [3:0] e_cls;
      logic [7:0] e_conf;
      en0 = en_cnt; q0 = got_pix.size(); fl0 = flush_cnt;
      exp_pix.delete();
      bad_ready = 0; early_res = 0; bad_hold = 0;
      for (int b = 1; b <= nbeats; b++) begin
         while ($urandom_range(0, 3) == 0) begin
            s_valid = 1'b0;
            core_valid = ($urandom_range(0, 7) == 0);
            core_class = 4'($urandom);
            tick();
         end
         if (s_ready !== 1'b1) bad_ready++;
         s_valid = 1'b1;
         s_data = 1'($urandom_range(0, 1));
         s_last = (b == last_beat);
         core_valid = ($urandom_range(0, 7) == 0);
         core_class = 4'($urandom);
         core_conf = 8'($urandom);
         exp_pix.push_back(s_data);
         tick();
      end
      s_valid = 1'b0; s_last = 1'b0; s_data = 1'b0; core_valid = 1'b0;
      chk("s_ready_during_load", bad_ready, 0);
      chk("s_ready_after_last", s_ready, 0);
      chk("busy_after_last", busy, 1);
      if (last_beat >= 1 && last_beat < N) begin
         e_err = 2'b01; e_cls = '0; e_conf = '0;
      end else begin
         timed_out = !(core_lat >= 1 && core_lat <= TO);
         resp = timed_out ? TO : core_lat;
         e_err = {timed_out, last_beat != N};
         e_cls = timed_out ? 4'd0 : cls;
         e_conf = timed_out ? 8'd0 : conf;
         for (int i = 1; i <= resp; i++) begin
            if (res_valid !== 1'b0) early_res++;
            if (i == resp && !timed_out) begin
               core_valid = 1'b1; core_class = cls; core_conf = conf;
            end
            tick();
         end
         core_valid = 1'b0;
         chk("res_valid_low_in_wait", early_res, 0);
      end
      chk("res_valid", res_valid, 1);
      chk("res_class", res_class, e_cls);
      chk("res_conf", res_conf, e_conf);
      chk("res_err", res_err, e_err);
      for (int h = 0; h < hold; h++) begin
         core_valid = ($urandom_range(0, 3) == 0);
         core_class = 4'($urandom);
         core_conf = 8'($urandom);
         tick();
         if (res_valid !== 1'b1 || res_class !== e_cls || res_conf !== e_conf ||
             res_err !== e_err || s_ready !== 1'b0 || core_flush !== 1'b0) bad_hold++;
      end
      chk("hold_stable", bad_hold, 0);
      core_valid = 1'b0;
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
`ifdef BNN_FRAME_CNT_EN
      if (exp_fc < 65535) exp_fc++;
`endif
      chk("res_valid_after_hs", res_valid, 0);
      chk("core_flush_pulse", core_flush, 1);
      chk("s_ready_in_flush", s_ready, 0);
      tick();
      chk("core_flush_end", core_flush, 0);
      chk("s_ready_reopen", s_ready, 1);
      chk("busy_idle", busy, 0);
      chk("flush_count", flush_cnt - fl0, 1);
      chk("core_en_count", en_cnt - en0, nbeats);
      mism = 0;
      for (int j = 0; j < exp_pix.size() && (q0 + j) < got_pix.size(); j++)
         if (got_pix[q0 + j] !== exp_pix[j]) mism++;
      chk("core_pixel_seq", mism, 0);
      chk("frame_cnt", frame_cnt, exp_fc);
   endtask

   initial begin
      int lat;
      repeat (3) tick();
      check_reset_vals("in_reset");
      rst_n = 1'b1;
      tick();
      check_reset_vals("after_reset");

      run_frame(N, N, 20, 0, 4'd7, 8'd200);
      run_frame(N, N, 20, 50, 4'd7, 8'd200);
      run_frame(100, 100, 0, 3, 4'd0, 8'd0);
      run_frame(N, N, 0, 2, 4'd0, 8'd0);
      run_frame(N, N, TO, 1, 4'd5, 8'd77);

      for (int b = 0; b < 300; b++) begin
         s_valid = 1'b1; s_data = 1'($urandom_range(0, 1)); s_last = 1'b0;
         tick();
      end
      chk("busy_mid_load", busy, 1);
      s_valid = 1'b0;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      exp_fc = 0;
      check_reset_vals("mid_load_reset");
      tick();

      run_frame(N, N, 20, 0, 4'd3, 8'd42);
      run_frame(N, 0, 9, 1, 4'd9, 8'd255);
      for (int r = 0; r < 3; r++) begin
         lat = $urandom_range(1, TO + 4);
         run_frame(N, N, lat, $urandom_range(0, 5), 4'($urandom_range(0, NCLS - 1)),
                   8'($urandom));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
